counter: RTL and testbench
==========================

# counter

Parameterised synchronous up/down counter with a 2-bit command input. Serves as the count engine for clock dividers and timing blocks: the parent drives `control` each cycle (increment, decrement, hold, clear) and compares `count_out` against its own terminal value. All state changes occur on the rising clock edge; there is no combinational path from inputs to `count_out`.

## Interface
Parameters:
- `WIDTH`, default 4: bit width of `count_out`. Supported range is 1 to 32. It is the first and only parameter, so positional override `#(w)` sets it.

Ports:
- `clk`, input, 1: rising-edge clock. The block uses one clock.
- `rst`, input, 1: reset, synchronous and active-high. When high at a rising edge, `count_out` becomes 0.
- `control`, input, 2: command, sampled every rising edge.
  - 2'b00: hold.
  - 2'b01: increment.
  - 2'b10: decrement.
  - 2'b11: clear to 0.
- `count_out`, output, WIDTH: registered count value.
- `at_max`, output, 1: combinational flag, high when `count_out` equals 2^WIDTH−1.
- `at_zero`, output, 1: combinational flag, high when `count_out` equals 0.

Port names and positions of `control`, `clk` and `count_out` are fixed for existing parents. `rst` must work when tied low or left unconnected; parents that rely on the power-up value do this.

## Operation
- Single WIDTH-bit register `count`, driven directly to `count_out`.
- Power-up/initial value of `count` is 0. This is an initial value on the register for FPGA and simulation, independent of `rst`.
- Priority at each rising edge, highest first:
  1. `rst`=1: count ← 0.
  2. `control`=11: count ← 0 (synchronous clear).
  3. `control`=01: count ← count+1, modulo 2^WIDTH.
  4. `control`=10: count ← count−1, modulo 2^WIDTH.
  5. `control`=00: count unchanged.
- Arithmetic is unsigned and truncated to WIDTH bits.
  - Increment from 2^WIDTH−1 wraps to 0.
  - Decrement from 0 wraps to 2^WIDTH−1.
- `at_max` and `at_zero` are decoded from the register only; they never depend on `control` or `rst` combinationally.
- X/Z on `control` is not a supported input. The bench must drive a legal value at every active edge.

## Timing
- Latency: a command sampled at edge k is visible on `count_out` immediately after edge k (one-cycle register update). Flags follow in the same cycle.
- Reset value: `count_out`=0, `at_zero`=1, `at_max`=0. For WIDTH=1, `at_max`=0 and `at_zero`=1 after reset.
- `rst` asserted mid-count clears on the next edge regardless of `control`. The first command after `rst` deasserts acts on the value 0.
- A clear (11) issued in the same cycle as `at_max`=1 yields 0, not a wrap-plus-clear.
- Parent compare-and-clear usage:
  - The parent drives 11 combinationally when `count_out`==N−1, otherwise 01.
  - This gives the repeating sequence 0,1,…,N−1,0 with period N cycles.
  - There is no combinational loop, because `control` depends only on the registered `count_out`.
- `count_out` changes only on rising `clk` edges. It is glitch-free between edges.

## Test plan
- Power-up/reset (WIDTH=4): no `rst`, `control`=00 for 3 edges → `count_out`=0 throughout. Pulse `rst` with `control`=01 → 0 on the following edge.
- Increment and wrap (WIDTH=4): `control`=01 for 17 edges from 0 → sequence 1…15, 0, 1.
  - `at_max`=1 only while the count is 15.
  - `at_zero`=1 only while the count is 0.
- Decrement and wrap (WIDTH=3): from 0, `control`=10 for 2 edges → 7, then 6. Hold with 00 for 4 edges → stays 6.
- Clear and priority (WIDTH=4):
  - Count to 9, then apply 11 → 0 next edge.
  - Count to 5, then apply `rst`=1 together with `control`=01 → 0 (reset wins).
  - `rst`=1 with `control`=10 → 0.
- Divider usage (WIDTH=2): drive 11 when `count_out`==1, else 01 → `count_out` alternates 0,1,0,1. The clear command occurs every 2nd cycle.
- WIDTH=1 edge case: `control`=01 for 3 edges → 1, 0, 1; `control`=10 from 1 → 0.

Source files
------------

// File: rtl/counter.sv
// rtl/counter.sv - parameterised synchronous up/down counter with hold/clear commands
// Flags decode the registered count only, so no input reaches an output combinationally.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] count_out,
  output logic             at_max,
  output logic             at_zero
);

  typedef enum logic [1:0] {
    CMD_HOLD  = 2'b00,
    CMD_INC   = 2'b01,
    CMD_DEC   = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  // Initial value gives the power-up count for parents that tie rst low.
  logic [WIDTH-1:0] count_q = '0;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case (cmd_e'(control))
      CMD_INC:   count_d = count_q + COUNT_ONE;
      CMD_DEC:   count_d = count_q - COUNT_ONE;
      CMD_CLEAR: count_d = '0;
      default:   count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;
  assign at_max    = (count_q == COUNT_MAX);
  assign at_zero   = (count_q == '0);

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - scoreboard bench for counter at WIDTH 4, 3, 2 and 1
// Stimulus pushes model predictions per edge; a monitor pops and compares after each edge.
module tb_counter;

  typedef struct {
    int idx;
    int cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic [3:0] rst_v = 4'b0000;
  logic [1:0] ctl_v [4];

  logic [3:0] c4;
  logic [2:0] c3;
  logic [1:0] c2;
  logic [0:0] c1;
  logic [3:0] amax, azero;

  int   widths [4] = '{4, 3, 2, 1};
  int   model  [4] = '{0, 0, 0, 0};
  bit   div_mode = 1'b0;
  exp_t sb_q [$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  counter #(4) u_w4 (.clk(clk), .rst(rst_v[0]), .control(ctl_v[0]), .count_out(c4), .at_max(amax[0]), .at_zero(azero[0]));
  counter #(3) u_w3 (.clk(clk), .rst(rst_v[1]), .control(ctl_v[1]), .count_out(c3), .at_max(amax[1]), .at_zero(azero[1]));
  counter #(2) u_w2 (.clk(clk), .rst(rst_v[2]), .control(ctl_v[2]), .count_out(c2), .at_max(amax[2]), .at_zero(azero[2]));
  counter #(1) u_w1 (.clk(clk), .rst(rst_v[3]), .control(ctl_v[3]), .count_out(c1), .at_max(amax[3]), .at_zero(azero[3]));

  function automatic int next_count(int w, int cur, bit r, logic [1:0] c);
    int m;
    m = 1 << w;
    if (r) return 0;
    case (c)
      2'b11:   return 0;
      2'b01:   return (cur + 1) % m;
      2'b10:   return (cur + m - 1) % m;
      default: return cur;
    endcase
  endfunction

  function automatic int actual_count(int i);
    case (i)
      0:       return int'(c4);
      1:       return int'(c3);
      2:       return int'(c2);
      default: return int'(c1);
    endcase
  endfunction

  task automatic check(string name, int i, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s dut%0d (w=%0d): actual=%0d required=%0d", name, i, widths[i], act, req);
    end
  endtask

  // Inputs are already applied; predict the next edge, push, then move to the next falling edge.
  task automatic tick();
    exp_t e;
    if (div_mode) ctl_v[2] = (model[2] == 1) ? 2'b11 : 2'b01;
    for (int i = 0; i < 4; i++) begin
      model[i] = next_count(widths[i], model[i], rst_v[i], ctl_v[i]);
      e.idx = i;
      e.cnt = model[i];
      sb_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drive(int i, bit r, logic [1:0] c, int n);
    rst_v[i] = r;
    ctl_v[i] = c;
    repeat (n) tick();
    rst_v[i] = 1'b0;
    ctl_v[i] = 2'b00;
  endtask

  initial begin : monitor
    exp_t e;
    int   mx;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        mx = (1 << widths[e.idx]) - 1;
        check("count_out", e.idx, actual_count(e.idx), e.cnt);
        check("at_max", e.idx, int'(amax[e.idx]), (e.cnt == mx) ? 1 : 0);
        check("at_zero", e.idx, int'(azero[e.idx]), (e.cnt == 0) ? 1 : 0);
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 4; i++) ctl_v[i] = 2'b00;

    repeat (3) tick();                       // power-up value, no reset

    drive(0, 1'b1, 2'b01, 1);                // reset beats increment
    drive(0, 1'b0, 2'b01, 17);               // 1..15, 0, 1
    drive(1, 1'b0, 2'b10, 2);                // 7, 6
    drive(1, 1'b0, 2'b00, 4);                // hold at 6

    drive(0, 1'b0, 2'b01, 8);                // reach 9
    drive(0, 1'b0, 2'b11, 1);
    drive(0, 1'b0, 2'b01, 5);                // reach 5
    drive(0, 1'b1, 2'b01, 1);
    drive(0, 1'b0, 2'b01, 3);
    drive(0, 1'b1, 2'b10, 1);
    drive(0, 1'b0, 2'b10, 1);                // first command after reset acts on 0
    drive(0, 1'b0, 2'b11, 1);                // clear while at_max

    div_mode = 1'b1;
    repeat (8) tick();
    div_mode = 1'b0;
    ctl_v[2] = 2'b00;

    drive(3, 1'b0, 2'b01, 3);                // 1, 0, 1
    drive(3, 1'b0, 2'b10, 1);                // 0

    repeat (400) begin
      for (int i = 0; i < 4; i++) begin
        rst_v[i] = ($urandom_range(0, 15) == 0);
        ctl_v[i] = 2'($urandom_range(0, 3));
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b0;
      ctl_v[i] = 2'b00;
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 0, sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
